// File: rtl/switch_mcu_fetch_pkg.sv
// Shared types and constants for the switch MCU fetch/sequencer block.
// The CYCLES_PER_INST legality check lives here so every user applies the same bounds.
package switch_mcu_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    EXEC = 2'd1,
    ERR  = 2'd2
  } fetch_state_e;

  localparam logic [3:0]  CNT_IDLE   = 4'hF;
  localparam int          INST_BYTES = 4;
  localparam logic [31:0] NOP_INST   = 32'h0000_0013;

  localparam int CPI_MIN = 2;
  localparam int CPI_MAX = 15;

  function automatic bit cpi_legal(input int cpi);
    return (cpi >= CPI_MIN) && (cpi <= CPI_MAX);
  endfunction

endpackage

// File: rtl/switch_mcu_fetch_if.sv
// Instruction-memory fetch port between the fetch block (master) and imem (slave).
interface switch_mcu_fetch_if;

  // Handshake: out_imem_req stays high with out_imem_addr stable until a rising
  // clock edge samples in_imem_ack high; that edge completes the transfer and
  // in_imem_rdata/in_imem_err are only meaningful on it. Ack while req is low is ignored.
  logic        out_imem_req;
  logic [31:0] out_imem_addr;
  logic        in_imem_ack;
  logic [31:0] in_imem_rdata;
  logic        in_imem_err;

  modport master (
    output out_imem_req,
    output out_imem_addr,
    input  in_imem_ack,
    input  in_imem_rdata,
    input  in_imem_err
  );

  modport slave (
    input  out_imem_req,
    input  out_imem_addr,
    output in_imem_ack,
    output in_imem_rdata,
    output in_imem_err
  );

endinterface

// File: rtl/switch_mcu_fetch_cycle_counter.sv
// Per-instruction execute step counter: idles at CNT_IDLE, loads 0 on fetch,
// advances when enabled and not stalled, and flags the final step.
module switch_mcu_cycle_counter
  import switch_mcu_pkg::*;
#(
  parameter int CYCLES_PER_INST = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic       stall_i,
  input  logic       load_zero_i,
  input  logic       force_idle_i,
  output logic [3:0] cnt_o,
  output logic       last_o
);

  localparam logic [3:0] LAST_STEP = 4'(CYCLES_PER_INST - 1);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // Force-idle wins over load so a terminal fault can never restart counting.
  always_comb begin
    cnt_d = cnt_q;
    if (force_idle_i) begin
      cnt_d = CNT_IDLE;
    end else if (load_zero_i) begin
      cnt_d = 4'd0;
    end else if (en_i && !stall_i) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= CNT_IDLE;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = en_i && (cnt_q == LAST_STEP);

endmodule

// File: rtl/switch_mcu_fetch.sv
// Instruction fetch and cycle sequencer: fetches one word per instruction, presents it
// for CYCLES_PER_INST execute steps, then fetches the sequential or redirected PC.
module switch_mcu_fetch
  import switch_mcu_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          CYCLES_PER_INST = 8
) (
  input  logic                in_clk,
  input  logic                in_rst,
  input  logic                in_stall,
  input  logic                in_redirect_valid,
  input  logic [31:0]         in_redirect_pc,
  switch_mcu_fetch_if.master  imem,
  output logic [31:0]         out_inst,
  output logic [3:0]          out_cycle_cnt,
  output logic                out_inst_valid,
  output logic [31:0]         out_pc,
  output logic                out_fetch_err,
  output fetch_state_e        out_dbg_state
);

  if (!cpi_legal(CYCLES_PER_INST) || (RESET_PC[1:0] != 2'b00)) begin : g_param_check
    $error("switch_mcu_fetch: illegal CYCLES_PER_INST or misaligned RESET_PC");
  end

  fetch_state_e state_q, state_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  inst_q, inst_d;
  logic         pend_q, pend_d;
  logic [31:0]  pend_pc_q, pend_pc_d;

  logic         cnt_load_zero;
  logic         cnt_force_idle;
  logic         cnt_last;
  logic [3:0]   cnt;
  logic [31:0]  seq_pc;
  logic [31:0]  next_pc;

  switch_mcu_cycle_counter #(
    .CYCLES_PER_INST(CYCLES_PER_INST)
  ) u_cycle_counter (
    .clk_i       (in_clk),
    .rst_ni      (in_rst),
    .en_i        (state_q == EXEC),
    .stall_i     (in_stall),
    .load_zero_i (cnt_load_zero),
    .force_idle_i(cnt_force_idle),
    .cnt_o       (cnt),
    .last_o      (cnt_last)
  );

  // A redirect arriving on the final step beats any earlier pending target.
  assign seq_pc  = pc_q + 32'(INST_BYTES);
  assign next_pc = in_redirect_valid ? in_redirect_pc : (pend_q ? pend_pc_q : seq_pc);

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    pc_d           = pc_q;
    inst_d         = inst_q;
    pend_d         = pend_q;
    pend_pc_d      = pend_pc_q;
    cnt_load_zero  = 1'b0;
    cnt_force_idle = 1'b0;
    unique case (state_q)
      REQ: begin
        if (imem.in_imem_ack) begin
          if (imem.in_imem_err) begin
            state_d = ERR;
          end else begin
            inst_d        = imem.in_imem_rdata;
            pc_d          = addr_q;
            cnt_load_zero = 1'b1;
            state_d       = EXEC;
          end
        end
      end
      EXEC: begin
        if (in_redirect_valid) begin
          pend_d    = 1'b1;
          pend_pc_d = in_redirect_pc;
        end
        if (cnt_last && !in_stall) begin
          pend_d         = 1'b0;
          cnt_force_idle = 1'b1;
          addr_d         = next_pc;
          state_d        = (next_pc[1:0] != 2'b00) ? ERR : REQ;
        end
      end
      ERR: begin
        cnt_force_idle = 1'b1;
      end
      default: begin
        state_d        = ERR;
        cnt_force_idle = 1'b1;
      end
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state_q   <= REQ;
      addr_q    <= RESET_PC;
      pc_q      <= RESET_PC;
      inst_q    <= NOP_INST;
      pend_q    <= 1'b0;
      pend_pc_q <= 32'h0000_0000;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  assign imem.out_imem_req  = (state_q == REQ);
  assign imem.out_imem_addr = addr_q;
  assign out_inst           = inst_q;
  assign out_pc             = pc_q;
  assign out_cycle_cnt      = cnt;
  assign out_inst_valid     = (state_q == EXEC);
  assign out_fetch_err      = (state_q == ERR);
  assign out_dbg_state      = state_q;

endmodule

// File: tb/tb_switch_mcu_fetch.sv
// Bench for switch_mcu_fetch: directed scenarios plus randomized traffic, all checked
// every cycle against an instruction-level model and a fetched-instruction queue.
module tb_switch_mcu_fetch;

  localparam int          CPI = 8;
  localparam logic [31:0] NOP = 32'h0000_0013;

  // ---------------- clock / reset / DUT ----------------
  logic        in_clk = 1'b0;
  logic        in_rst = 1'b0;
  logic        in_stall = 1'b0;
  logic        in_redirect_valid = 1'b0;
  logic [31:0] in_redirect_pc = 32'h0;
  logic [31:0] out_inst;
  logic [3:0]  out_cycle_cnt;
  logic        out_inst_valid;
  logic [31:0] out_pc;
  logic        out_fetch_err;
  switch_mcu_pkg::fetch_state_e out_dbg_state;

  switch_mcu_fetch_if imem();

  always #5 in_clk = ~in_clk;

  switch_mcu_fetch #(
    .RESET_PC       (32'h0000_0000),
    .CYCLES_PER_INST(CPI)
  ) dut (
    .in_clk           (in_clk),
    .in_rst           (in_rst),
    .in_stall         (in_stall),
    .in_redirect_valid(in_redirect_valid),
    .in_redirect_pc   (in_redirect_pc),
    .imem             (imem.master),
    .out_inst         (out_inst),
    .out_cycle_cnt    (out_cycle_cnt),
    .out_inst_valid   (out_inst_valid),
    .out_pc           (out_pc),
    .out_fetch_err    (out_fetch_err),
    .out_dbg_state    (out_dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Instruction-level view: either waiting for a fetch, executing step m_step, or faulted.
  bit          m_fetching, m_fault, m_pend;
  int          m_step;
  logic [31:0] m_addr, m_pc, m_inst, m_pend_pc, m_next;
  logic [63:0] exp_q[$];

  always @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      m_fetching = 1'b1; m_fault = 1'b0; m_pend = 1'b0; m_step = -1;
      m_addr = 32'h0; m_pc = 32'h0; m_inst = NOP; m_pend_pc = 32'h0;
      exp_q.delete();
    end else if (m_fault) begin
      // terminal until reset
    end else if (m_fetching) begin
      if (imem.in_imem_ack) begin
        if (imem.in_imem_err) begin
          m_fault = 1'b1; m_fetching = 1'b0;
        end else begin
          m_inst = imem.in_imem_rdata; m_pc = m_addr; m_fetching = 1'b0; m_step = 0;
          exp_q.push_back({m_addr, imem.in_imem_rdata});
        end
      end
    end else if (!in_stall && m_step == CPI - 1) begin
      m_next = in_redirect_valid ? in_redirect_pc : (m_pend ? m_pend_pc : m_pc + 32'd4);
      m_pend = 1'b0; m_step = -1; m_addr = m_next;
      if (m_next[1:0] != 2'b00) m_fault = 1'b1;
      else m_fetching = 1'b1;
    end else begin
      if (in_redirect_valid) begin
        m_pend = 1'b1; m_pend_pc = in_redirect_pc;
      end
      if (!in_stall) m_step++;
    end
  end

  // ---------------- compare process / scoreboard ----------------
  logic [3:0]  prev_cnt = 4'hF;
  logic [63:0] sb_e;

  always @(negedge in_clk) begin
    if (chk_en) begin
      chk("req",   32'(imem.out_imem_req), 32'(!m_fault && m_fetching));
      if (!m_fault && m_fetching) chk("addr", imem.out_imem_addr, m_addr);
      chk("cnt",   32'(out_cycle_cnt), (m_step < 0) ? 32'hF : 32'(m_step));
      chk("valid", 32'(out_inst_valid), 32'(!m_fault && !m_fetching));
      chk("inst",  out_inst, m_inst);
      chk("pc",    out_pc, m_pc);
      chk("ferr",  32'(out_fetch_err), 32'(m_fault));
      if (out_inst_valid && out_cycle_cnt == 4'd0 && prev_cnt != 4'd0) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
          sb_e = exp_q.pop_front();
          chk("sb_pc", out_pc, sb_e[63:32]);
          chk("sb_inst", out_inst, sb_e[31:0]);
        end
      end
      prev_cnt = out_cycle_cnt;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    in_stall = 1'b0; in_redirect_valid = 1'b0; in_redirect_pc = 32'h0;
    imem.in_imem_ack = 1'b0; imem.in_imem_rdata = 32'h0; imem.in_imem_err = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge in_clk);
    #2 in_rst = 1'b0;
    idle_inputs();
    repeat (3) @(negedge in_clk);
    #2 in_rst = 1'b1;
  endtask

  task automatic wait_cnt(input int v);
    int k = 0;
    while (!(out_inst_valid && out_cycle_cnt == 4'(v)) && k < 100) begin
      @(negedge in_clk); k++;
    end
    chk("wait_cnt_timeout", 32'(k < 100), 32'd1);
  endtask

  task automatic wait_req();
    int k = 0;
    while (!imem.out_imem_req && k < 100) begin
      @(negedge in_clk); k++;
    end
    chk("wait_req_timeout", 32'(k < 100), 32'd1);
  endtask

  task automatic do_fetch(input logic [31:0] data);
    wait_req();
    imem.in_imem_ack = 1'b1; imem.in_imem_rdata = data; imem.in_imem_err = 1'b0;
    @(negedge in_clk);
    imem.in_imem_ack = 1'b0;
  endtask

  task automatic redirect_once(input logic [31:0] target);
    in_redirect_valid = 1'b1; in_redirect_pc = target;
    @(negedge in_clk);
    in_redirect_valid = 1'b0;
  endtask

  task automatic toggle_in_fault();
    for (int i = 0; i < 20; i++) begin
      in_stall = 1'($urandom); in_redirect_valid = 1'($urandom); in_redirect_pc = $urandom;
      imem.in_imem_ack = 1'($urandom); imem.in_imem_rdata = $urandom; imem.in_imem_err = 1'($urandom);
      @(negedge in_clk);
      chk("fault_ferr", 32'(out_fetch_err), 32'd1);
      chk("fault_req", 32'(imem.out_imem_req), 32'd0);
      chk("fault_cnt", 32'(out_cycle_cnt), 32'hF);
      chk("fault_valid", 32'(out_inst_valid), 32'd0);
    end
    idle_inputs();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t;
    int k;
    int fault_cycles;
    logic [31:0] r;
    idle_inputs();
    repeat (2) @(negedge in_clk);
    chk_en = 1'b1;

    // first fetch: ack on the second request cycle
    do_reset();
    @(negedge in_clk);
    chk("rst_cnt0", 32'(out_cycle_cnt), 32'hF);
    chk("rst_req", 32'(imem.out_imem_req), 32'd1);
    chk("rst_addr", imem.out_imem_addr, 32'h0);
    chk("rst_inst", out_inst, NOP);
    @(negedge in_clk);
    chk("rst_cnt1", 32'(out_cycle_cnt), 32'hF);
    imem.in_imem_ack = 1'b1; imem.in_imem_rdata = 32'h0050_0093;
    @(negedge in_clk);
    imem.in_imem_ack = 1'b0;
    chk("model_inst", m_inst, 32'h0050_0093);
    for (int i = 0; i < CPI; i++) begin
      chk("t1_cnt", 32'(out_cycle_cnt), 32'(i));
      chk("t1_inst", out_inst, 32'h0050_0093);
      chk("t1_pc", out_pc, 32'h0);
      @(negedge in_clk);
    end
    chk("t1_req", 32'(imem.out_imem_req), 32'd1);
    chk("t1_next_addr", imem.out_imem_addr, 32'h4);

    // single redirect mid-instruction
    do_fetch(32'h0010_0113);
    wait_cnt(3);
    redirect_once(32'h0000_0100);
    wait_req();
    chk("t2_redirect_addr", imem.out_imem_addr, 32'h100);

    // two redirects, last one wins
    do_fetch(32'h0020_0193);
    wait_cnt(2);
    redirect_once(32'h0000_0040);
    wait_cnt(7);
    redirect_once(32'h0000_0080);
    wait_req();
    chk("t3_last_wins", imem.out_imem_addr, 32'h80);

    // stall five cycles at step 4; instruction period grows to 8+5+1
    wait_req();
    imem.in_imem_ack = 1'b1; imem.in_imem_rdata = 32'h0030_0213;
    @(negedge in_clk);
    imem.in_imem_ack = 1'b0;
    t = 1;
    repeat (4) @(negedge in_clk);
    t += 4;
    chk("t4_pre_stall", 32'(out_cycle_cnt), 32'd4);
    in_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t4_stall_hold", 32'(out_cycle_cnt), 32'd4);
      @(negedge in_clk); t++;
    end
    in_stall = 1'b0;
    while (!imem.out_imem_req && t < 100) begin
      @(negedge in_clk); t++;
    end
    chk("t4_period", 32'(t), 32'(CPI + 5 + 1));

    // PC wrap, with stray acks during EXEC
    do_fetch(32'h0040_0293);
    wait_cnt(1);
    redirect_once(32'hFFFF_FFFC);
    wait_req();
    chk("t5_top_addr", imem.out_imem_addr, 32'hFFFF_FFFC);
    do_fetch(32'h1234_5013);
    k = 0;
    while (!imem.out_imem_req && k < 50) begin
      chk("t5_inst_hold", out_inst, 32'h1234_5013);
      imem.in_imem_ack = 1'b1; imem.in_imem_rdata = $urandom; imem.in_imem_err = 1'($urandom);
      @(negedge in_clk); k++;
    end
    imem.in_imem_ack = 1'b0; imem.in_imem_err = 1'b0;
    chk("t5_wrap_addr", imem.out_imem_addr, 32'h0);
    chk("t5_wrap_pc", out_pc, 32'hFFFF_FFFC);
    chk("model_wrap", m_addr, 32'h0);

    // misaligned redirect target faults
    do_fetch(32'h0050_0313);
    wait_cnt(5);
    redirect_once(32'h0000_0102);
    k = 0;
    while (!out_fetch_err && k < 20) begin
      @(negedge in_clk); k++;
    end
    chk("t6_misalign_err", 32'(out_fetch_err), 32'd1);
    toggle_in_fault();

    // bus error on fetch faults
    do_reset();
    wait_req();
    imem.in_imem_ack = 1'b1; imem.in_imem_err = 1'b1; imem.in_imem_rdata = 32'hDEAD_BEEF;
    @(negedge in_clk);
    imem.in_imem_ack = 1'b0; imem.in_imem_err = 1'b0;
    chk("t7_bus_err", 32'(out_fetch_err), 32'd1);
    chk("t7_inst_kept", out_inst, NOP);
    toggle_in_fault();

    // randomized traffic
    do_reset();
    fault_cycles = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge in_clk);
      in_stall = ($urandom_range(0, 3) == 0);
      in_redirect_valid = ($urandom_range(0, 9) == 0);
      r = $urandom;
      r[1:0] = ($urandom_range(0, 79) == 0) ? 2'b10 : 2'b00;
      in_redirect_pc = r;
      imem.in_imem_ack = ($urandom_range(0, 2) == 0);
      imem.in_imem_rdata = $urandom;
      imem.in_imem_err = ($urandom_range(0, 99) == 0);
      if (out_fetch_err) fault_cycles++;
      if (fault_cycles > 5) begin
        fault_cycles = 0;
        do_reset();
      end
    end
    idle_inputs();
    repeat (2) @(negedge in_clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish, miscompares so far %0d", n_err);
    $fatal(1, "watchdog");
  end

endmodule
